// File: rtl/chess_board_mem.sv
// Board-state RAM with a command/response handshake, a start-position init sequencer
// and an atomic, legality-checked move (read src, read dst, write dst, clear src).
module chess_board_mem #(
  parameter int unsigned PIECE_W   = 6,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned SQUARES   = 64,
  parameter int unsigned INIT_MODE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [ADDR_W-1:0]  cmd_addr_a,
  input  logic [ADDR_W-1:0]  cmd_addr_b,
  input  logic [PIECE_W-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [PIECE_W-1:0] rsp_data,
  output logic               rsp_err,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_MV_RS, S_MV_RD, S_MV_CHK, S_MV_WD, S_MV_WS, S_RESP
  } state_t;

  localparam logic [1:0]        OP_RD     = 2'b00;
  localparam logic [1:0]        OP_WR     = 2'b01;
  localparam logic [1:0]        OP_MV     = 2'b10;
  localparam logic [ADDR_W:0]   SQ_LIM    = (ADDR_W+1)'(SQUARES);
  localparam logic [ADDR_W-1:0] LAST_SQ   = ADDR_W'(SQUARES - 1);
  localparam bit                START_POS = (INIT_MODE == 1) && (SQUARES == 64);

  // Start-position code for a square: rank 0/7 back ranks, rank 1/6 pawns.
  function automatic logic [PIECE_W-1:0] start_code(input logic [ADDR_W-1:0] sq);
    int unsigned file;
    int unsigned rank;
    int unsigned code;
    file = 32'(sq) % 8;
    rank = 32'(sq) / 8;
    case (rank)
      0:       code = 9 + file;
      1:       code = 1 + file;
      6:       code = 17 + file;
      7:       code = 25 + file;
      default: code = 0;
    endcase
    return PIECE_W'(code);
  endfunction

  // 1 = white, 2 = black, 0 = empty or colourless code.
  function automatic logic [1:0] colour(input logic [PIECE_W-1:0] p);
    if (p == '0) return 2'd0;
    else if (p <= PIECE_W'(16)) return 2'd1;
    else if (p <= PIECE_W'(32)) return 2'd2;
    return 2'd0;
  endfunction

  state_t               state, state_n;
  logic [PIECE_W-1:0]   mem [SQUARES];
  logic [PIECE_W-1:0]   rd_q, src_q, pend_d_q;
  logic [ADDR_W-1:0]    init_idx, addr_a_q, addr_b_q;
  logic                 reinit_q, pend_rd_q, pend_e_q;

  logic                 mem_we, mem_re;
  logic [ADDR_W-1:0]    mem_wa, mem_ra;
  logic [PIECE_W-1:0]   mem_wd, init_val, rsp_d, pend_d_n;
  logic                 rsp_set, rsp_e, init_clr, init_done, mv_ld, src_ld;
  logic                 pend_ld, pend_rd_n, pend_e_n;
  logic                 a_bad, b_bad, mv_err;
  logic [1:0]           src_col, dst_col;

  assign init_val = START_POS ? start_code(init_idx) : '0;
  assign a_bad    = {1'b0, cmd_addr_a} >= SQ_LIM;
  assign b_bad    = {1'b0, cmd_addr_b} >= SQ_LIM;
  assign src_col  = colour(src_q);
  assign dst_col  = colour(rd_q);
  // In MV_CHK, src_q holds the source piece and rd_q the destination piece.
  assign mv_err   = (src_q == '0) || (addr_a_q == addr_b_q) ||
                    ((src_col != 2'd0) && (src_col == dst_col));

  always_ff @(posedge clk) begin
    if (!reset) state <= S_INIT;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    mem_we    = 1'b0;
    mem_wa    = init_idx;
    mem_wd    = init_val;
    mem_re    = 1'b0;
    mem_ra    = addr_a_q;
    rsp_set   = 1'b0;
    rsp_d     = '0;
    rsp_e     = 1'b0;
    init_clr  = 1'b0;
    init_done = 1'b0;
    mv_ld     = 1'b0;
    src_ld    = 1'b0;
    pend_ld   = 1'b0;
    pend_rd_n = 1'b0;
    pend_d_n  = '0;
    pend_e_n  = 1'b0;
    case (state)
      S_INIT: begin
        mem_we = 1'b1;
        if (init_idx == LAST_SQ) begin
          state_n   = S_IDLE;
          init_done = 1'b1;
          rsp_set   = reinit_q;
        end
      end
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          pend_ld = 1'b1;
          state_n = S_RESP;
          case (cmd_op)
            OP_RD: begin
              if (a_bad) pend_e_n = 1'b1;
              else begin
                mem_re    = 1'b1;
                mem_ra    = cmd_addr_a;
                pend_rd_n = 1'b1;
              end
            end
            OP_WR: begin
              if (a_bad) pend_e_n = 1'b1;
              else begin
                mem_we = 1'b1;
                mem_wa = cmd_addr_a;
                mem_wd = cmd_data;
              end
            end
            OP_MV: begin
              if (a_bad || b_bad) pend_e_n = 1'b1;
              else begin
                mv_ld   = 1'b1;
                state_n = S_MV_RS;
              end
            end
            default: begin
              init_clr = 1'b1;
              state_n  = S_INIT;
            end
          endcase
        end
      end
      S_MV_RS: begin
        mem_re  = 1'b1;
        mem_ra  = addr_a_q;
        state_n = S_MV_RD;
      end
      S_MV_RD: begin
        mem_re  = 1'b1;
        mem_ra  = addr_b_q;
        src_ld  = 1'b1;
        state_n = S_MV_CHK;
      end
      S_MV_CHK: begin
        pend_ld = 1'b1;
        if (mv_err) begin
          pend_e_n = 1'b1;
          pend_d_n = src_q;
          state_n  = S_RESP;
        end else begin
          pend_d_n = rd_q;
          state_n  = S_MV_WD;
        end
      end
      S_MV_WD: begin
        mem_we  = 1'b1;
        mem_wa  = addr_b_q;
        mem_wd  = src_q;
        state_n = S_MV_WS;
      end
      S_MV_WS: begin
        mem_we  = 1'b1;
        mem_wa  = addr_a_q;
        mem_wd  = '0;
        state_n = S_RESP;
      end
      S_RESP: begin
        rsp_set = 1'b1;
        rsp_d   = pend_rd_q ? rd_q : pend_d_q;
        rsp_e   = pend_e_q;
        state_n = S_IDLE;
      end
      default: state_n = S_INIT;
    endcase
  end

  // Writes are suppressed while reset is low so an aborted move leaves no partial update.
  always_ff @(posedge clk) begin
    if (mem_we && reset) mem[mem_wa] <= mem_wd;
    if (mem_re) rd_q <= mem[mem_ra];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      init_idx  <= '0;
      reinit_q  <= 1'b0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      src_q     <= '0;
      pend_rd_q <= 1'b0;
      pend_d_q  <= '0;
      pend_e_q  <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      cmd_ready <= (state_n == S_IDLE);
      busy      <= (state_n != S_IDLE);
      rsp_valid <= rsp_set;
      if (rsp_set) begin
        rsp_data <= rsp_d;
        rsp_err  <= rsp_e;
      end
      if (state == S_INIT) init_idx <= init_idx + ADDR_W'(1);
      if (init_clr) begin
        init_idx <= '0;
        reinit_q <= 1'b1;
      end
      if (init_done) reinit_q <= 1'b0;
      if (mv_ld) begin
        addr_a_q <= cmd_addr_a;
        addr_b_q <= cmd_addr_b;
      end
      if (src_ld) src_q <= rd_q;
      if (pend_ld) begin
        pend_rd_q <= pend_rd_n;
        pend_d_q  <= pend_d_n;
        pend_e_q  <= pend_e_n;
      end
    end
  end

endmodule

// File: tb/tb_chess_board_mem.sv
// Directed bench for chess_board_mem: a board/latency model predicts every response,
// and a per-cycle checker compares handshake, busy and response outputs against it.
module tb_chess_board_mem;

  localparam int unsigned PIECE_W = 6;
  localparam int unsigned ADDR_W  = 6;
  localparam int          NEVER   = 2147483647;

  logic               clk = 1'b0;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [ADDR_W-1:0]  cmd_addr_a;
  logic [ADDR_W-1:0]  cmd_addr_b;
  logic [PIECE_W-1:0] cmd_data;
  logic               rsp_valid;
  logic [PIECE_W-1:0] rsp_data;
  logic               rsp_err;
  logic               busy;

  always #5 clk = ~clk;

  chess_board_mem dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr_a (cmd_addr_a),
    .cmd_addr_b (cmd_addr_b),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state, written only by the stimulus process.
  int board [64];
  bit pending   = 1'b0;
  int rsp_cycle = 0;
  int rdy_cycle = NEVER;
  int exp_d     = 0;
  int exp_e     = 0;
  int want_d    = -1;
  int want_e    = -1;

  // Checker state.
  int   nchk   = 0;
  int   nfail  = 0;
  int   hold_d = 0;
  int   hold_e = 0;
  logic exp_v;
  logic exp_r;

  function automatic int colour(input int p);
    if (p == 0) return 0;
    if (p <= 16) return 1;
    if (p <= 32) return 2;
    return 3;
  endfunction

  // Place each of the 32 piece IDs on its home square.
  function automatic void load_start();
    int side, k, file, rank;
    for (int s = 0; s < 64; s++) board[s] = 0;
    for (int c = 1; c <= 32; c++) begin
      side = (c - 1) / 16;
      k    = (c - 1) % 16;
      if (k < 8) begin
        file = k;
        rank = (side == 1) ? 6 : 1;
      end else begin
        file = k - 8;
        rank = (side == 1) ? 7 : 0;
      end
      board[rank * 8 + file] = c;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    exp_v = pending && (cyc == rsp_cycle);
    exp_r = (cyc >= rdy_cycle);
    if (!reset) begin
      hold_d = 0;
      hold_e = 0;
    end
    if (exp_v) begin
      hold_d = exp_d;
      hold_e = exp_e;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    chk("cmd_ready", 32'(cmd_ready), 32'(exp_r));
    chk("busy", 32'(busy), 32'(!exp_r));
    chk("rsp_data", 32'(rsp_data), hold_d);
    chk("rsp_err", 32'(rsp_err), hold_e);
    if (exp_v && want_d >= 0) chk("lit_data", 32'(rsp_data), want_d);
    if (exp_v && want_e >= 0) chk("lit_err", 32'(rsp_err), want_e);
  end

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic send(input logic [1:0] op, input int a, input int b, input int d,
                      input int wd, input int we, input bit hold);
    int lat, rd, re, n, s, t;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      $display("FAIL ready_timeout at cycle %0d: cmd_ready still 0, expected 1", cyc);
      $fatal(1, "bench stopped waiting for cmd_ready");
    end
    rd  = 0;
    re  = 0;
    lat = 1;
    case (op)
      2'b00: rd = board[a];
      2'b01: board[a] = d;
      2'b10: begin
        s = board[a];
        t = board[b];
        if (s == 0 || a == b || (t != 0 && colour(s) == colour(t) && colour(s) != 3)) begin
          lat = 4;
          re  = 1;
          rd  = s;
        end else begin
          lat      = 6;
          rd       = t;
          board[b] = s;
          board[a] = 0;
        end
      end
      default: begin
        lat = 64;
        load_start();
      end
    endcase
    pending    = 1'b1;
    rsp_cycle  = cyc + 1 + lat;
    rdy_cycle  = rsp_cycle;
    exp_d      = rd;
    exp_e      = re;
    want_d     = wd;
    want_e     = we;
    cmd_op     = op;
    cmd_addr_a = ADDR_W'(a);
    cmd_addr_b = ADDR_W'(b);
    cmd_data   = PIECE_W'(d);
    cmd_valid  = 1'b1;
    @(negedge clk);
    if (hold) while (cyc < rsp_cycle) @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic cmd(input logic [1:0] op, input int a, input int b, input int d,
                     input int wd, input int we, input bit hold);
    send(op, a, b, d, wd, we, hold);
    while (cyc < rsp_cycle) @(negedge clk);
  endtask

  task automatic rd_sq(input int a, input int want);
    cmd(2'b00, a, 0, 0, want, 0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b0;
    pending   = 1'b0;
    rdy_cycle = NEVER;
    repeat (n) @(negedge clk);
    reset     = 1'b1;
    rdy_cycle = cyc + 64;
    load_start();
  endtask

  initial begin
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_addr_a = '0;
    cmd_addr_b = '0;
    cmd_data   = '0;
    do_reset(2);

    // Start position after power-up init.
    rd_sq(0, 9);
    rd_sq(4, 13);
    rd_sq(8, 1);
    rd_sq(20, 0);
    rd_sq(52, 21);
    rd_sq(60, 29);
    rd_sq(63, 32);

    // e2-e4, then the pawn captures the e7 pawn.
    cmd(2'b10, 12, 28, 0, 0, 0, 1'b0);
    rd_sq(28, 5);
    rd_sq(12, 0);
    cmd(2'b10, 28, 52, 0, 21, 0, 1'b0);
    rd_sq(52, 5);
    rd_sq(28, 0);

    // Illegal moves: empty source, src == dst, same-colour capture.
    cmd(2'b10, 20, 36, 0, 0, 1, 1'b0);
    cmd(2'b10, 0, 0, 0, 9, 1, 1'b0);
    cmd(2'b10, 0, 8, 0, 9, 1, 1'b0);
    rd_sq(0, 9);
    rd_sq(8, 1);

    // Write/read round trip, then a black pawn blocked by a black piece.
    cmd(2'b01, 35, 0, 30, 0, 0, 1'b0);
    rd_sq(35, 30);
    cmd(2'b10, 51, 35, 0, 20, 1, 1'b0);

    // Colourless code on the board can be captured by white.
    cmd(2'b01, 40, 0, 40, 0, 0, 1'b0);
    cmd(2'b10, 1, 40, 0, 40, 0, 1'b0);
    rd_sq(40, 10);

    // cmd_valid held throughout a move must not be re-accepted.
    cmd(2'b10, 13, 21, 0, 0, 0, 1'b1);
    rd_sq(21, 6);

    // Reset while the move sits in its destination-write step.
    send(2'b10, 11, 19, 0, -1, -1, 1'b0);
    while (cyc < rsp_cycle - 3) @(negedge clk);
    do_reset(2);
    rd_sq(19, 0);
    rd_sq(11, 4);
    rd_sq(28, 0);
    rd_sq(52, 21);
    rd_sq(35, 0);
    rd_sq(1, 10);

    // Reinit command restores the start position and answers once.
    cmd(2'b01, 0, 0, 7, 0, 0, 1'b0);
    rd_sq(0, 7);
    cmd(2'b11, 0, 0, 0, 0, 0, 1'b0);
    rd_sq(0, 9);
    rd_sq(40, 0);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
